// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The WB_ARB_TIMEOUT_EN build macro (see wishbone_bus_arbiter) uses WB_ARB_TIMEOUT_DATA.
package wb_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    typedef logic master_id_t;
    localparam logic [31:0] WB_ARB_TIMEOUT_DATA = 32'hDEADDEAD;
endpackage

// File: rtl/wb_arb_picker.sv
// Combinational winner selection between the two masters.
// A lone requester always wins; ties go round-robin or to m1.
module wb_arb_picker
    import wb_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  master_id_t rr_last,
    output master_id_t winner
);
    always_comb begin
        winner = req[1];
        if (&req) winner = (ROUND_ROBIN != 0) ? ~rr_last : 1'b1;
    end
endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Two-master Wishbone arbiter (m0 = fetch, m1 = LSU) with registered grant.
// Define WB_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module wishbone_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m0_strobe,
    input  logic                    m0_write_enable,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic [DATA_WIDTH-1:0]   m0_data_out,
    input  logic [DATA_WIDTH/8-1:0] m0_sel,
    output logic [DATA_WIDTH-1:0]   m0_data_in,
    output logic                    m0_ack,
    input  logic                    m1_strobe,
    input  logic                    m1_write_enable,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic [DATA_WIDTH-1:0]   m1_data_out,
    input  logic [DATA_WIDTH/8-1:0] m1_sel,
    output logic [DATA_WIDTH-1:0]   m1_data_in,
    output logic                    m1_ack,
    output logic                    s_cyc,
    output logic                    s_strobe,
    output logic                    s_write_enable,
    output logic [ADDR_WIDTH-1:0]   s_address,
    output logic [DATA_WIDTH-1:0]   s_data_out,
    output logic [DATA_WIDTH/8-1:0] s_sel,
    input  logic [DATA_WIDTH-1:0]   s_data_in,
    input  logic                    s_ack,
    output logic [1:0]              o_grant
);
    arb_state_t state_q, state_d;
    logic [1:0] grant_d;
    master_id_t rr_q, rr_d, winner, owner;
    logic       to_hit;

    logic [1:0]                   req, we, ack_vec;
    logic [1:0][ADDR_WIDTH-1:0]   addr;
    logic [1:0][DATA_WIDTH-1:0]   wdata, rdata;
    logic [1:0][DATA_WIDTH/8-1:0] sel;

    assign req   = {m1_strobe, m0_strobe};
    assign we    = {m1_write_enable, m0_write_enable};
    assign addr  = {m1_address, m0_address};
    assign wdata = {m1_data_out, m0_data_out};
    assign sel   = {m1_sel, m0_sel};
    assign owner = o_grant[1];

    wb_arb_picker #(.ROUND_ROBIN(ROUND_ROBIN)) u_picker (
        .req     (req),
        .rr_last (rr_q),
        .winner  (winner)
    );

    // Slave side follows the registered owner only, never a live strobe.
    assign s_write_enable = we[owner];
    assign s_address      = addr[owner];
    assign s_data_out     = wdata[owner];
    assign s_sel          = sel[owner];
    assign m0_ack         = ack_vec[0];
    assign m1_ack         = ack_vec[1];
    assign m0_data_in     = rdata[0];
    assign m1_data_in     = rdata[1];

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  cnt_q <= '0;
        else if (state_q == ARB_IDLE) cnt_q <= '0;
        else                        cnt_q <= cnt_q + 1'b1;
    end

    assign to_hit = (state_q == ARB_BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            o_grant <= 2'b00;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            o_grant <= grant_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = o_grant;
        rr_d     = rr_q;
        ack_vec  = '0;
        rdata    = '0;
        s_cyc    = 1'b0;
        s_strobe = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    state_d = ARB_BUSY;
                    grant_d = winner ? 2'b10 : 2'b01;
                end
            end
            ARB_BUSY: begin
                s_cyc    = 1'b1;
                s_strobe = 1'b1;
                if (!req[owner]) begin
                    // Owner gave up: a late slave ack in this cycle is dropped.
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                end else if (s_ack) begin
                    ack_vec[owner] = 1'b1;
                    rdata[owner]   = s_data_in;
                    state_d        = ARB_IDLE;
                    grant_d        = 2'b00;
                    rr_d           = owner;
                end else if (to_hit) begin
                    ack_vec[owner] = 1'b1;
                    rdata[owner]   = DATA_WIDTH'(WB_ARB_TIMEOUT_DATA);
                    state_d        = ARB_IDLE;
                    grant_d        = 2'b00;
                    rr_d           = owner;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end
endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Directed bench: dut_a is round-robin, dut_b fixed priority; both watchdog limit 8.
module tb_wishbone_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        m0_strobe, m1_strobe, b0_strobe, b1_strobe;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] s_rd;
    logic        s_ack, s_ack_b;

    logic [31:0] a_m0_rd, a_m1_rd, a_s_addr, a_s_wd;
    logic        a_m0_ack, a_m1_ack, a_s_cyc, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;
    logic [31:0] b_m0_rd, b_m1_rd, b_s_addr, b_s_wd;
    logic        b_m0_ack, b_m1_ack, b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    wishbone_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .reset(reset),
        .m0_strobe(m0_strobe), .m0_write_enable(m0_we), .m0_address(m0_addr),
        .m0_data_out(m0_wd), .m0_sel(m0_sel), .m0_data_in(a_m0_rd), .m0_ack(a_m0_ack),
        .m1_strobe(m1_strobe), .m1_write_enable(m1_we), .m1_address(m1_addr),
        .m1_data_out(m1_wd), .m1_sel(m1_sel), .m1_data_in(a_m1_rd), .m1_ack(a_m1_ack),
        .s_cyc(a_s_cyc), .s_strobe(a_s_stb), .s_write_enable(a_s_we), .s_address(a_s_addr),
        .s_data_out(a_s_wd), .s_sel(a_s_sel), .s_data_in(s_rd), .s_ack(s_ack), .o_grant(a_grant)
    );

    wishbone_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset),
        .m0_strobe(b0_strobe), .m0_write_enable(m0_we), .m0_address(m0_addr),
        .m0_data_out(m0_wd), .m0_sel(m0_sel), .m0_data_in(b_m0_rd), .m0_ack(b_m0_ack),
        .m1_strobe(b1_strobe), .m1_write_enable(m1_we), .m1_address(m1_addr),
        .m1_data_out(m1_wd), .m1_sel(m1_sel), .m1_data_in(b_m1_rd), .m1_ack(b_m1_ack),
        .s_cyc(b_s_cyc), .s_strobe(b_s_stb), .s_write_enable(b_s_we), .s_address(b_s_addr),
        .s_data_out(b_s_wd), .s_sel(b_s_sel), .s_data_in(s_rd), .s_ack(s_ack_b), .o_grant(b_grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    // Tie-break order per round: dut_a alternates, dut_b always m1.
    logic [1:0] exp_a [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        reset = 1'b1;
        {m0_strobe, m1_strobe, b0_strobe, b1_strobe, s_ack, s_ack_b} = '0;
        {m0_we, m1_we} = '0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wd = 32'h0; m1_wd = 32'h0;
        m0_sel = 4'hF; m1_sel = 4'hF; s_rd = 32'h0;
        tick(); tick();
        @(negedge clk);
        chk("rst_grant", a_grant, 2'b00);
        chk("rst_stb", {a_s_cyc, a_s_stb}, 2'b00);
        chk("rst_ack", {a_m0_ack, a_m1_ack}, 2'b00);
        chk("rst_rd", a_m0_rd, 32'h0);
        reset = 1'b0;

        // 1: lone m1 read, slave acks two cycles after grant.
        tick();
        m1_strobe = 1'b1; m1_addr = 32'h1000;
        tick();
        @(negedge clk);
        chk("t1_grant", a_grant, 2'b10);
        chk("t1_addr", a_s_addr, 32'h1000);
        chk("t1_stb", a_s_stb, 1'b1);
        tick(); tick();
        s_ack = 1'b1; s_rd = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_ack", {a_m0_ack, a_m1_ack}, 2'b01);
        chk("t1_rd", a_m1_rd, 32'hDEADBEEF);
        chk("t1_m0rd", a_m0_rd, 32'h0);
        tick();
        s_ack = 1'b0; m1_strobe = 1'b0;
        @(negedge clk);
        chk("t1_idle", a_grant, 2'b00);
        chk("t1_noack", a_m1_ack, 1'b0);

        // 2/3: continuous ties on both duts; one idle bubble between grants.
        m0_strobe = 1'b1; m1_strobe = 1'b1; b0_strobe = 1'b1; b1_strobe = 1'b1;
        s_rd = 32'h12345678;
        for (int r = 0; r < 4; r++) begin
            tick();
            s_ack = 1'b1; s_ack_b = 1'b1;
            @(negedge clk);
            chk($sformatf("tie_a_grant%0d", r), a_grant, exp_a[r]);
            chk($sformatf("tie_a_ack%0d", r), {a_m1_ack, a_m0_ack}, exp_a[r]);
            chk($sformatf("tie_b_grant%0d", r), b_grant, 2'b10);
            chk($sformatf("tie_b_ack%0d", r), {b_m1_ack, b_m0_ack}, 2'b10);
            tick();
            s_ack = 1'b0; s_ack_b = 1'b0;
            if (r == 3) begin
                m0_strobe = 1'b0; m1_strobe = 1'b0; b0_strobe = 1'b0; b1_strobe = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("tie_bubble%0d", r), {a_grant, b_grant}, 4'b0000);
        end

        // 4: m1 write queued behind an m0 write.
        m0_strobe = 1'b1; m0_we = 1'b1; m0_addr = 32'h3000; m0_wd = 32'h11112222;
        tick();
        m1_strobe = 1'b1; m1_we = 1'b1; m1_addr = 32'h2000; m1_wd = 32'hCAFEBABE;
        @(negedge clk);
        chk("t4_grant0", a_grant, 2'b01);
        chk("t4_wd0", a_s_wd, 32'h11112222);
        tick();
        @(negedge clk);
        chk("t4_wd0b", a_s_wd, 32'h11112222);
        chk("t4_addr0", a_s_addr, 32'h3000);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("t4_ack0", {a_m1_ack, a_m0_ack}, 2'b01);
        tick();
        s_ack = 1'b0; m0_strobe = 1'b0; m0_we = 1'b0;
        @(negedge clk);
        chk("t4_bubble", a_grant, 2'b00);
        tick();
        @(negedge clk);
        chk("t4_grant1", a_grant, 2'b10);
        chk("t4_wd1", a_s_wd, 32'hCAFEBABE);
        chk("t4_addr1", a_s_addr, 32'h2000);
        chk("t4_we1", a_s_we, 1'b1);
        tick();
        s_ack = 1'b1;
        @(negedge clk);
        chk("t4_ack1", {a_m1_ack, a_m0_ack}, 2'b10);
        tick();
        s_ack = 1'b0; m1_strobe = 1'b0; m1_we = 1'b0;

        // 5: reset while busy, then late ack; also owner abort.
        m0_strobe = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_busy", a_s_stb, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_stb", {a_s_cyc, a_s_stb}, 2'b00);
        chk("t5_rst_grant", a_grant, 2'b00);
        tick();
        reset = 1'b0; m0_strobe = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        chk("t5_late_ack", {a_m1_ack, a_m0_ack}, 2'b00);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("t5_idle", a_grant, 2'b00);
        m1_strobe = 1'b1;
        tick();
        m1_strobe = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        chk("t5_abort_ack", a_m1_ack, 1'b0);
        tick();
        @(negedge clk);
        chk("t5_abort_idle", a_grant, 2'b00);
        chk("t5_abort_ack2", a_m1_ack, 1'b0);
        tick();
        s_ack = 1'b0;

        // 6: slave never acks.
        m0_strobe = 1'b1;
        tick();
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            chk($sformatf("t6_wait%0d", n), a_m0_ack, 1'b0);
            tick();
        end
        @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
        chk("t6_to_ack", a_m0_ack, 1'b1);
        chk("t6_to_data", a_m0_rd, 32'hDEADDEAD);
        tick();
        m0_strobe = 1'b0;
        @(negedge clk);
        chk("t6_to_idle", {a_grant, a_s_cyc}, 3'b000);
`else
        chk("t6_no_to_ack", a_m0_ack, 1'b0);
        chk("t6_held", {a_grant, a_s_cyc}, 3'b011);
        tick();
        m0_strobe = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_abort_idle", a_grant, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
